lenet_downscale: RTL

LENET_DOWNSCALE -- requirements
Module: lenet_downscale

---
 rtl/lenet_pkg.sv | 28 ++
 rtl/rgb444_to_gray.sv | 36 +++
 rtl/lenet_downscale.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/lenet_pkg.sv
// Shared types and constants for the LeNet input downscaler: FSM states,
// luma coefficients and the default capture/crop geometry.
package lenet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_ACCUM      = 2'd2,
    ST_DONE       = 2'd3
  } state_e;

  localparam logic [15:0] COEF_R = 16'd77;
  localparam logic [15:0] COEF_G = 16'd150;
  localparam logic [15:0] COEF_B = 16'd29;

  localparam int DEF_SRC_W   = 640;
  localparam int DEF_SRC_H   = 480;
  localparam int DEF_BLK     = 16;
  localparam int DEF_OUT_DIM = 28;
  localparam int DEF_X0      = 96;
  localparam int DEF_Y0      = 16;

  localparam int PIX_W  = 12;
  localparam int GRAY_W = 8;
  localparam int ACC_W  = 16;
  localparam int ADDR_W = 10;

endpackage

// File: rtl/rgb444_to_gray.sv
// Stage-1 converter: RGB444 pixel to 8-bit luma, registered on each
// accepted pixel.
module rgb444_to_gray
  import lenet_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [PIX_W-1:0]  pix_data,
  output logic [GRAY_W-1:0] gray_p1_q
);

  // Nibbles are replicated to full 8-bit range before weighting; the
  // weighted sum tops out at 255*256 so 16 bits never overflow.
  function automatic logic [GRAY_W-1:0] to_gray(input logic [PIX_W-1:0] p);
    logic [15:0] rr, gg, bb, sum;
    rr  = {8'd0, p[11:8], p[11:8]};
    gg  = {8'd0, p[7:4], p[7:4]};
    bb  = {8'd0, p[3:0], p[3:0]};
    sum = rr * COEF_R + gg * COEF_G + bb * COEF_B;
    return sum[15:8];
  endfunction

  logic [GRAY_W-1:0] gray_p1_d;

  always_comb begin
    gray_p1_d = gray_p1_q;
    if (en) gray_p1_d = to_gray(pix_data);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) gray_p1_q <= '0;
    else     gray_p1_q <= gray_p1_d;
  end

endmodule

// File: rtl/lenet_downscale.sv
// Crops a raster RGB444 stream, averages BLKxBLK luma blocks and writes an
// OUT_DIM x OUT_DIM grayscale image into a result buffer, one frame per start.
module lenet_downscale
  import lenet_pkg::*;
#(
  parameter int SRC_W   = DEF_SRC_W,
  parameter int SRC_H   = DEF_SRC_H,
  parameter int BLK     = DEF_BLK,
  parameter int OUT_DIM = DEF_OUT_DIM,
  parameter int X0      = DEF_X0,
  parameter int Y0      = DEF_Y0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              busy,
  output logic              done,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [GRAY_W-1:0] out_data
);

  localparam int XW        = $clog2(SRC_W);
  localparam int YW        = $clog2(SRC_H);
  localparam int CW        = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int CROP      = BLK * OUT_DIM;
  localparam int LAST_ADDR = OUT_DIM * OUT_DIM - 1;

  state_e state_q;
  logic   busy_q, done_q;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [15:0]   xe, ye, dx, dy;
  logic          in_crop, take, fs_clear, discard;

  logic              vld_p1_q, vld_p1_d;
  logic              last_p1_q, last_p1_d;
  logic [CW-1:0]     col_p1_q, col_p1_d;
  logic [ADDR_W-1:0] addr_p1_q, addr_p1_d;
  logic [GRAY_W-1:0] gray_p1;

  logic [ACC_W-1:0]  acc_q [OUT_DIM];
  logic [ACC_W-1:0]  acc_d [OUT_DIM];
  logic [ACC_W-1:0]  acc_sum;
  logic              out_we_q, out_we_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [GRAY_W-1:0] out_data_q, out_data_d;

  // Control: busy covers start acceptance through the final write; done is
  // raised in the cycle after the last address leaves the write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_WAIT_FRAME;
            busy_q  <= 1'b1;
          end
        end
        ST_WAIT_FRAME: begin
          if (frame_start) state_q <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (out_we_q && out_addr_q == ADDR_W'(LAST_ADDR)) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Stage 0: raster position, crop test and block bookkeeping.
  always_comb begin
    fs_clear = frame_start && (state_q == ST_WAIT_FRAME || state_q == ST_ACCUM);
    discard  = frame_start && (state_q == ST_ACCUM);
    take     = pix_valid && !frame_start && (state_q == ST_ACCUM);

    xe = 16'(x_q);
    ye = 16'(y_q);
    dx = xe - 16'(X0);
    dy = ye - 16'(Y0);
    in_crop = (xe >= 16'(X0)) && (xe < 16'(X0 + CROP)) &&
              (ye >= 16'(Y0)) && (ye < 16'(Y0 + CROP));

    vld_p1_d  = take && in_crop;
    last_p1_d = (dx % 16'(BLK) == 16'(BLK - 1)) && (dy % 16'(BLK) == 16'(BLK - 1));
    col_p1_d  = CW'(dx / 16'(BLK));
    addr_p1_d = ADDR_W'((dy / 16'(BLK)) * 16'(OUT_DIM) + dx / 16'(BLK));

    x_d = x_q;
    y_d = y_q;
    if (fs_clear) begin
      x_d = '0;
      y_d = '0;
    end else if (take) begin
      if (x_q == XW'(SRC_W - 1)) begin
        x_d = '0;
        y_d = (y_q == YW'(SRC_H - 1)) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Stage 1: luma conversion runs alongside the registered metadata.
  rgb444_to_gray u_gray (
    .clk       (clk),
    .rst       (rst),
    .en        (take),
    .pix_data  (pix_data),
    .gray_p1_q (gray_p1)
  );

  // Stage 2: accumulate; the block's final pixel is folded into the write.
  always_comb begin
    acc_d      = acc_q;
    out_we_d   = 1'b0;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    acc_sum    = acc_q[col_p1_q] + {8'd0, gray_p1};
    if (discard) begin
      for (int i = 0; i < OUT_DIM; i++) acc_d[i] = '0;
    end else if (vld_p1_q) begin
      if (last_p1_q) begin
        acc_d[col_p1_q] = '0;
        out_we_d        = 1'b1;
        out_addr_d      = addr_p1_q;
        out_data_d      = acc_sum[15:8];
      end else begin
        acc_d[col_p1_q] = acc_sum;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      vld_p1_q   <= 1'b0;
      last_p1_q  <= 1'b0;
      col_p1_q   <= '0;
      addr_p1_q  <= '0;
      out_we_q   <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      for (int i = 0; i < OUT_DIM; i++) acc_q[i] <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      vld_p1_q   <= vld_p1_d;
      last_p1_q  <= last_p1_d;
      col_p1_q   <= col_p1_d;
      addr_p1_q  <= addr_p1_d;
      out_we_q   <= out_we_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      acc_q      <= acc_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign out_we   = out_we_q;
  assign out_addr = out_addr_q;
  assign out_data = out_data_q;

endmodule
